// File: rtl/hpsplatform_fifo_pkg.sv
// Shared constants and CSR layout for the HPS platform FIFO bridges.
// Both transfer directions decode the same register map from this package.
package hpsplatform_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int DEPTH_DEF      = 1024;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CSR  = 1'b1;

  localparam int FLUSH_BIT = 0;
  localparam int LEVEL_LSB = 0;
  localparam int LEVEL_W   = 11;
  localparam int EMPTY_BIT = 11;
  localparam int FULL_BIT  = 12;

  typedef struct packed {
    logic               full;
    logic               empty;
    logic [LEVEL_W-1:0] level;
  } csr_status_t;

  // Places the status fields at their register bit positions; unused bits read 0.
  function automatic logic [31:0] pack_status(input csr_status_t s);
    logic [31:0] v;
    v = '0;
    v[FULL_BIT]               = s.full;
    v[EMPTY_BIT]              = s.empty;
    v[LEVEL_LSB +: LEVEL_W]   = s.level;
    return v;
  endfunction

endpackage

// File: rtl/hpsplatform_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// The storage array carries no reset so it maps onto block RAM.
module hpsplatform_sdp_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read data holds its value while i_rd_en is low; the top relies on that.
  always_ff @(posedge i_clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/hpsplatform_mm_to_st_fifo.sv
// Avalon-MM write slave to Avalon-ST source FIFO with a level/status/flush CSR.
// Words flow RAM -> RAM read register -> show-ahead output register.
module hpsplatform_mm_to_st_fifo
  import hpsplatform_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  wrclock,
  input  logic                  reset,
  input  logic                  avalonmm_write_slave_address,
  input  logic                  avalonmm_write_slave_write,
  input  logic [DATA_WIDTH-1:0] avalonmm_write_slave_writedata,
  input  logic                  avalonmm_write_slave_read,
  output logic [31:0]           avalonmm_write_slave_readdata,
  output logic                  avalonmm_write_slave_waitrequest,
  output logic [DATA_WIDTH-1:0] avalonst_source_data,
  output logic                  avalonst_source_valid,
  input  logic                  avalonst_source_ready
);

  localparam int               LVL_W    = ADDR_WIDTH + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [LVL_W-1:0]      r_level;
  logic [LVL_W-1:0]      r_ram_count;
  logic                  r_q_valid;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [31:0]           r_readdata;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_data_sel;
  logic                  w_csr_sel;
  logic                  w_wr_acc;
  logic                  w_flush;
  logic                  w_pop;
  logic                  w_q_to_out;
  logic                  w_rd_en;
  logic [DATA_WIDTH-1:0] w_ram_q;
  csr_status_t           w_status;

  assign w_full     = (r_level == LVL_FULL);
  assign w_empty    = (r_level == '0);
  assign w_data_sel = (avalonmm_write_slave_address == ADDR_DATA);
  assign w_csr_sel  = (avalonmm_write_slave_address == ADDR_CSR);

  assign w_wr_acc = avalonmm_write_slave_write & w_data_sel & ~w_full;
  assign w_flush  = avalonmm_write_slave_write & w_csr_sel
                  & avalonmm_write_slave_writedata[FLUSH_BIT];
  assign avalonmm_write_slave_waitrequest = avalonmm_write_slave_write & w_data_sel & w_full;

  assign w_pop = r_out_valid & avalonst_source_ready;

  // The RAM read register acts as a second stage: it drains into the output
  // register when that register is free or popped, and a new read is issued
  // only when the read register will be free at the next edge. This keeps
  // one word per cycle without ever dropping the read result under backpressure.
  assign w_q_to_out = r_q_valid & (~r_out_valid | w_pop);
  assign w_rd_en    = (r_ram_count != '0) & (~r_q_valid | w_q_to_out) & ~w_flush;

  hpsplatform_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .i_clk     (wrclock),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (avalonmm_write_slave_writedata),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_ram_q)
  );

  always_ff @(posedge wrclock) begin
    if (reset || w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
    end
  end

  // r_level spans RAM, read register and output register; r_ram_count only
  // the words still in the RAM. Neither relies on pointer equality.
  always_ff @(posedge wrclock) begin
    if (reset || w_flush) begin
      r_level     <= '0;
      r_ram_count <= '0;
    end else begin
      case ({w_wr_acc, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
      case ({w_wr_acc, w_rd_en})
        2'b10:   r_ram_count <= r_ram_count + LVL_ONE;
        2'b01:   r_ram_count <= r_ram_count - LVL_ONE;
        default: r_ram_count <= r_ram_count;
      endcase
    end
  end

  // Clearing r_q_valid on flush discards any read already in flight.
  always_ff @(posedge wrclock) begin
    if (reset || w_flush) begin
      r_q_valid   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_rd_en) begin
        r_q_valid <= 1'b1;
      end else if (w_q_to_out) begin
        r_q_valid <= 1'b0;
      end
      if (w_q_to_out) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_ram_q;
      end else if (w_pop) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign w_status.full  = w_full;
  assign w_status.empty = w_empty;
  assign w_status.level = LEVEL_W'(r_level);

  always_ff @(posedge wrclock) begin
    if (reset) begin
      r_readdata <= '0;
    end else if (avalonmm_write_slave_read) begin
      r_readdata <= w_csr_sel ? pack_status(w_status) : 32'h0;
    end
  end

  assign avalonmm_write_slave_readdata = r_readdata;
  assign avalonst_source_data          = r_out_data;
  assign avalonst_source_valid         = r_out_valid;

endmodule
